// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: op classes, opcode/funct constants, field positions
// and the loader state encoding. The control decoder consumes the same opcode constants.
package mips_isa_pkg;

   typedef enum logic [3:0] {
      OPC_RTYPE = 4'd0,
      OPC_LW    = 4'd1,
      OPC_SW    = 4'd2,
      OPC_BEQ   = 4'd3,
      OPC_ADDI  = 4'd4,
      OPC_ANDI  = 4'd5,
      OPC_ORI   = 4'd6,
      OPC_SLTI  = 4'd7,
      OPC_J     = 4'd8
   } op_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_e;

   function automatic logic [31:0] itype_word(input logic [5:0] op6, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
      return (32'(op6) << OPCODE_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
   endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// instr_field_packer: combinational op class + fields -> 32-bit MIPS word and illegal flag.
module instr_field_packer
   import mips_isa_pkg::*;
(
   input  logic [3:0]    op_i,
   input  instr_fields_t fields_i,
   output logic [31:0]   word_o,
   output logic          illegal_o
);

   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (op_i)
         OPC_RTYPE: word_o = (32'(OP_RTYPE) << OPCODE_LSB) | (32'(fields_i.rs) << RS_LSB) |
                             (32'(fields_i.rt) << RT_LSB) | (32'(fields_i.rd) << RD_LSB) |
                             (32'(fields_i.shamt) << SHAMT_LSB) | 32'(fields_i.funct);
         OPC_LW:    word_o = itype_word(OP_LW,   fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_SW:    word_o = itype_word(OP_SW,   fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_BEQ:   word_o = itype_word(OP_BEQ,  fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_ADDI:  word_o = itype_word(OP_ADDI, fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_ANDI:  word_o = itype_word(OP_ANDI, fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_ORI:   word_o = itype_word(OP_ORI,  fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_SLTI:  word_o = itype_word(OP_SLTI, fields_i.rs, fields_i.rt, fields_i.imm);
         OPC_J:     word_o = (32'(OP_J) << OPCODE_LSB) | 32'(fields_i.target);
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: accepts field bundles, encodes them and writes words to imem
// one cycle after acceptance. Optional running checksum output under INSTR_LOADER_CHECKSUM_EN.
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
`ifdef INSTR_LOADER_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

   ld_state_e         state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_q, err_d;
   logic [ADDR_W+1:0] used;
   logic              new_session;
   instr_fields_t     fields;
   logic [31:0]       pk_word;
   logic              pk_illegal;

   assign fields = {in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target};

   instr_field_packer u_packer (
      .op_i      (in_op),
      .fields_i  (fields),
      .word_o    (pk_word),
      .illegal_o (pk_illegal)
   );

   // Words already written plus the one in flight; bounds acceptance against DEPTH.
   assign used        = {1'b0, count_q} + (ADDR_W+2)'(we_q);
   assign new_session = start && (state_q != ST_LOAD);

   always_comb begin
      state_d  = state_q;
      we_d     = 1'b0;
      wdata_d  = wdata_q;
      addr_d   = addr_q + ADDR_W'(we_q);
      count_d  = count_q + (ADDR_W+1)'(we_q);
      err_d    = err_q;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               addr_d  = BASE_W;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            in_ready = !finish && (used < DEPTH_W);
            if (finish) begin
               state_d = ST_DONE;
            end else if (in_valid && in_ready) begin
               if (pk_illegal) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  wdata_d = pk_word;
                  if (used + 1'b1 == DEPTH_W) state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= BASE_W;
         wdata_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q + (we_q ? wdata_q : 32'd0);
      if (new_session) sum_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   assign checksum = sum_q;
`else
   logic unused_ns;
   assign unused_ns = new_session;
`endif

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = (state_q == ST_LOAD);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;
   assign count      = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer side of the instruction-decode path: packs symbolic instruction fields into 32-bit MIPS words and writes them sequentially into instruction memory.
- The opcodes it emits are exactly the ones the main control decoder consumes.
- Used for boot and test program loading before the core is released from reset.
- Valid/ready input stream; one-cycle write pipeline to the memory write port.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of words the loader may write (DEPTH ≤ 2^ADDR_W).
- BASE_ADDR, 0, word address of the first write after start.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begin a new load session.
- finish  in  1  pulse; end the session after any pending write.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader accepts the bundle this cycle.
- in_op  in  4  class: 0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=ANDI 6=ORI 7=SLTI 8=J; 9-15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount (RTYPE only).
- in_funct  in  6  function code (RTYPE only).
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- err  out  1  sticky illegal-op flag.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset values: state IDLE; imem_we 0; imem_addr BASE_ADDR; imem_wdata 0; count 0; err 0; in_ready 0.
- States and transitions:
  - IDLE --start--> LOAD. On this transition: address ← BASE_ADDR, count ← 0, err ← 0.
  - LOAD: in_ready = 1 while count + pending < DEPTH. "pending" is 1 when a write is scheduled for the next cycle.
  - A bundle is accepted when in_valid && in_ready.
- Encoding, registered in the accept cycle; imem_we pulses the following cycle (latency 1, throughput 1 word/cycle):
  - RTYPE: {6'b000000, rs, rt, rd, shamt, funct}.
  - LW/SW/BEQ/ADDI/ANDI/ORI/SLTI: {op6, rs, rt, imm}, with op6 = 100011 / 101011 / 000100 / 001000 / 001100 / 001101 / 001010.
  - J: {6'b000010, target}.
  - Fields not used by a class are ignored.
- Address and count update: after each write, imem_addr increments by 1 and count increments by 1. Address wraps modulo 2^ADDR_W.
- Illegal in_op:
  - Bundle is consumed (in_ready honoured) and err is set.
  - No write occurs; address and count are unchanged.
- Capacity end: when count reaches DEPTH, in_ready drops and the state moves to DONE in the same cycle as the final write.
- finish in LOAD:
  - If a write is pending, it completes first, then the state moves to DONE.
  - finish takes priority over a simultaneous in_valid; that bundle is not accepted.
- DONE: holds count and err; in_ready = 0. start returns to LOAD with a fresh session.
- Ignored inputs: start while in LOAD; finish in IDLE.
- Reset mid-session: any pending write is dropped (imem_we 0 in the next cycle) and all outputs return to their reset values.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0].
  - On every write, checksum ← checksum + imem_wdata, mod 2^32.
  - Cleared on reset and on start; held in DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_isa_pkg holds:
  - op-class enum;
  - 6-bit opcode constants, shared with the control decoder;
  - funct constants (ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010);
  - field-position constants.
- One natural sub-module: instr_field_packer, purely combinational, op + fields → {word, illegal}. The top holds the FSM, pipeline register and counters.

Test Plan:
- reset, start, RTYPE rs=8 rt=9 rd=10 shamt=0 funct=0x20 → imem_we one cycle later, addr=0, wdata=0x01095020, count=1.
- Back-to-back LW rs=29 rt=8 imm=4, then BEQ rs=8 rt=9 imm=0xFFFF → wdata 0x8FA80004 at addr 0, then 0x1109FFFF at addr 1, on consecutive cycles.
- J target=0x0100000, then ADDI rs=0 rt=8 imm=5 → 0x08100000, then 0x20080005.
- in_op=12 between two valid ops → err=1, no write for that bundle, addresses stay contiguous (0, 1).
- DEPTH=4: stream 6 bundles → exactly 4 writes, in_ready low after the 4th accept, done=1, count=4.
- finish asserted in the same cycle as an accept with in_valid high → pending word still written, new bundle not accepted, DONE next; reset mid-LOAD → imem_we 0 next cycle, state IDLE.
